// File: rtl/run_ctrl_pkg.sv
// Shared state encoding and parameter sanity checks for run_ctrl.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_END    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // True when every length is >=1 and both lengths fit the counter width.
  function automatic bit params_ok(input int rst_cycles, input int run_cycles,
                                   input int num_runs, input int cnt_w);
    longint lim;
    if (rst_cycles < 1 || run_cycles < 1 || num_runs < 1 || cnt_w < 1 || cnt_w > 62)
      return 1'b0;
    lim = longint'(1) << cnt_w;
    return (lim > longint'(rst_cycles)) && (lim > longint'(run_cycles));
  endfunction

endpackage

// File: rtl/run_ctrl_cyc_counter.sv
// cyc_counter: W-bit up-counter with synchronous clear, enable and terminal-count flag.
// Counting stops at the terminal value, so the counter never wraps.
module cyc_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_tc_val,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;
  logic         w_tc;

  assign w_tc = (r_cnt == i_tc_val);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)          r_cnt <= '0;
    else if (i_clr)        r_cnt <= '0;
    else if (i_en && !w_tc) r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;
  assign o_tc  = w_tc;

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: core-under-test sequencer (hold reset, run, end pulse, finish), NUM_RUNS runs per start.
// Build option RUN_CTRL_HALT_EN lets i_halt end a run early; otherwise halt is ignored.
//
//  state  | meaning
//  HOLD   | cpu_reset asserted for RST_CYCLES cycles
//  RUN    | core running, cycle_cnt counting
//  END    | one-cycle done pulse, cycle_cnt frozen
//  FINISH | all runs complete, waiting for start
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter  int RST_CYCLES = 5,
  parameter  int RUN_CYCLES = 500,
  parameter  int NUM_RUNS   = 1,
  parameter  int CNT_W      = 16,
  localparam int IDX_W      = $clog2(NUM_RUNS) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_halt,
  output logic             o_cpu_reset,
  output logic             o_running,
  output logic [IDX_W-1:0] o_run_idx,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic             o_done,
  output logic             o_timeout,
  output logic             o_finished
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RUNS - 1);
  localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_TC   = CNT_W'(RUN_CYCLES - 1);
`ifdef RUN_CTRL_HALT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  if (!params_ok(RST_CYCLES, RUN_CYCLES, NUM_RUNS, CNT_W)) begin : g_param_err
    $error("run_ctrl: invalid RST_CYCLES/RUN_CYCLES/NUM_RUNS/CNT_W");
  end

  state_t           r_state, w_next;
  logic [IDX_W-1:0] r_run_idx;
  logic             r_timeout;
  logic             w_halt;
  logic             w_hold_clr, w_hold_en, w_hold_tc;
  logic             w_run_clr, w_run_en, w_run_tc;
  logic             w_to_ld, w_to_val, w_idx_inc, w_idx_clr;
  logic [CNT_W-1:0] w_run_cnt;
  logic [CNT_W-1:0] w_hold_cnt_unused;

  assign w_halt = i_halt & HALT_EN;

  cyc_counter #(.W(CNT_W)) u_hold_cnt (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (w_hold_clr),
    .i_en     (w_hold_en),
    .i_tc_val (HOLD_TC),
    .o_cnt    (w_hold_cnt_unused),
    .o_tc     (w_hold_tc)
  );

  cyc_counter #(.W(CNT_W)) u_run_cnt (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (w_run_clr),
    .i_en     (w_run_en),
    .i_tc_val (RUN_TC),
    .o_cnt    (w_run_cnt),
    .o_tc     (w_run_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_HOLD;
      r_run_idx <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_idx_clr)      r_run_idx <= '0;
      else if (w_idx_inc) r_run_idx <= r_run_idx + IDX_W'(1);
      if (w_to_ld)        r_timeout <= w_to_val;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_hold_en = 1'b0;
    w_run_en  = 1'b0;
    w_to_ld   = 1'b0;
    w_to_val  = 1'b0;
    w_idx_inc = 1'b0;
    w_idx_clr = 1'b0;
    case (r_state)
      ST_HOLD: begin
        w_hold_en = 1'b1;
        if (w_hold_tc) w_next = ST_RUN;
      end
      ST_RUN: begin
        // halt takes priority over exhaustion when both land on the same cycle
        if (w_halt || w_run_tc) begin
          w_next   = ST_END;
          w_to_ld  = 1'b1;
          w_to_val = !w_halt;
        end else begin
          w_run_en = 1'b1;
        end
      end
      ST_END: begin
        if (r_run_idx == LAST_IDX) begin
          w_next = ST_FINISH;
        end else begin
          w_next    = ST_HOLD;
          w_idx_inc = 1'b1;
        end
      end
      ST_FINISH: begin
        if (i_start) begin
          w_next    = ST_HOLD;
          w_idx_clr = 1'b1;
          w_to_ld   = 1'b1;
        end
      end
      default: w_next = ST_HOLD;
    endcase
    w_hold_clr = (r_state != ST_HOLD);
    // clear on the edge into HOLD so cycle_cnt reads 0 from the first HOLD cycle
    w_run_clr  = (w_next == ST_HOLD) && (r_state != ST_HOLD);
  end

  assign o_cpu_reset = (r_state != ST_RUN);
  assign o_running   = (r_state == ST_RUN);
  assign o_done      = (r_state == ST_END);
  assign o_finished  = (r_state == ST_FINISH);
  assign o_run_idx   = r_run_idx;
  assign o_cycle_cnt = w_run_cnt;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: scoreboard bench for run_ctrl; one default instance and one 3-run short instance.
module tb_run_ctrl;

  typedef struct {
    int cyc;
    int cnt;
    int to;
    int idx;
    int len;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  int   len_a = 0;
  int   len_b = 0;

  logic        rst_a = 1'b0, start_a = 1'b0, halt_a = 1'b0;
  logic        cpu_reset_a, running_a, done_a, timeout_a, finished_a;
  logic [0:0]  run_idx_a;
  logic [15:0] cycle_cnt_a;

  logic        rst_b = 1'b0, start_b = 1'b0, halt_b = 1'b0;
  logic        cpu_reset_b, running_b, done_b, timeout_b, finished_b;
  logic [2:0]  run_idx_b;
  logic [15:0] cycle_cnt_b;

  run_ctrl u_dut_a (
    .i_clk(clk), .i_rst_n(rst_a), .i_start(start_a), .i_halt(halt_a),
    .o_cpu_reset(cpu_reset_a), .o_running(running_a), .o_run_idx(run_idx_a),
    .o_cycle_cnt(cycle_cnt_a), .o_done(done_a), .o_timeout(timeout_a),
    .o_finished(finished_a)
  );

  run_ctrl #(.RST_CYCLES(2), .RUN_CYCLES(4), .NUM_RUNS(3)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_b), .i_start(start_b), .i_halt(halt_b),
    .o_cpu_reset(cpu_reset_b), .o_running(running_b), .o_run_idx(run_idx_b),
    .o_cycle_cnt(cycle_cnt_b), .o_done(done_b), .o_timeout(timeout_b),
    .o_finished(finished_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitors: pop one expected record per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_a) len_a = 0;
    else if (running_a) len_a++;
    if (done_a) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_extra_done: done at cycle %0d, none expected", cyc);
      end else begin
        e = q_a.pop_front();
        chk("a_done_cycle", cyc, e.cyc);
        chk("a_done_cnt", cycle_cnt_a, e.cnt);
        chk("a_done_timeout", timeout_a, e.to);
        chk("a_done_idx", run_idx_a, e.idx);
        chk("a_run_len", len_a, e.len);
        chk("a_done_cpu_reset", cpu_reset_a, 1);
      end
      len_a = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_b) len_b = 0;
    else if (running_b) len_b++;
    if (done_b) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_extra_done: done at cycle %0d, none expected", cyc);
      end else begin
        e = q_b.pop_front();
        chk("b_done_cycle", cyc, e.cyc);
        chk("b_done_cnt", cycle_cnt_b, e.cnt);
        chk("b_done_timeout", timeout_b, e.to);
        chk("b_done_idx", run_idx_b, e.idx);
        chk("b_run_len", len_b, e.len);
      end
      len_b = 0;
    end
  end

  initial begin
    int t0, s, s2, s3, t4;
    repeat (3) @(negedge clk);
    chk("rst_cpu_reset", cpu_reset_a, 1);
    chk("rst_running", running_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_timeout", timeout_a, 0);
    chk("rst_finished", finished_a, 0);
    chk("rst_cycle_cnt", cycle_cnt_a, 0);
    chk("rst_run_idx", run_idx_a, 0);

    // Release both; cycle 0 is the cycle ending at the next rising edge.
    rst_a = 1'b1;
    rst_b = 1'b1;
    t0 = cyc;
    q_a.push_back('{t0 + 505, 499, 1, 0, 500});
    q_b.push_back('{t0 + 6, 3, 1, 0, 4});
    q_b.push_back('{t0 + 13, 3, 1, 1, 4});
    q_b.push_back('{t0 + 20, 3, 1, 2, 4});

    wait_cyc(t0 + 3);
    start_b = 1'b1;                 // ignored outside FINISH
    wait_cyc(t0 + 4);
    start_b = 1'b0;
    chk("a_hold_last_cpu_reset", cpu_reset_a, 1);
    chk("a_hold_last_running", running_a, 0);
    wait_cyc(t0 + 5);
    chk("a_run_first_cpu_reset", cpu_reset_a, 0);
    chk("a_run_first_running", running_a, 1);
    chk("a_run_first_cnt", cycle_cnt_a, 0);
    chk("b_run0_cnt", cycle_cnt_b, 3);
    wait_cyc(t0 + 7);
    chk("b_hold1_cpu_reset", cpu_reset_b, 1);
    chk("b_hold1_running", running_b, 0);
    chk("b_hold1_idx", run_idx_b, 1);
    chk("b_hold1_cnt_clear", cycle_cnt_b, 0);
    wait_cyc(t0 + 8);
    chk("b_hold1_cpu_reset2", cpu_reset_b, 1);
    wait_cyc(t0 + 14);
    chk("b_hold2_idx", run_idx_b, 2);
    chk("b_hold2_cpu_reset", cpu_reset_b, 1);
    wait_cyc(t0 + 21);
    chk("b_finished", finished_b, 1);
    chk("b_finish_idx", run_idx_b, 2);
    chk("b_finish_timeout", timeout_b, 1);
    wait_cyc(t0 + 25);
    chk("b_finish_hold", finished_b, 1);
    chk("b_finish_cnt_hold", cycle_cnt_b, 3);
    start_b = 1'b1;
    q_b.push_back('{t0 + 32, 3, 1, 0, 4});
    q_b.push_back('{t0 + 39, 3, 1, 1, 4});
    q_b.push_back('{t0 + 46, 3, 1, 2, 4});
    wait_cyc(t0 + 26);
    start_b = 1'b0;
    halt_b  = 1'b1;                 // halt in HOLD must not end anything
    chk("b_restart_idx", run_idx_b, 0);
    chk("b_restart_timeout", timeout_b, 0);
    chk("b_restart_cnt", cycle_cnt_b, 0);
    chk("b_restart_cpu_reset", cpu_reset_b, 1);
    wait_cyc(t0 + 28);
    halt_b = 1'b0;

    wait_cyc(t0 + 100);
    chk("a_cnt_mid", cycle_cnt_a, 95);
    wait_cyc(t0 + 504);
    chk("a_run_last_running", running_a, 1);
    chk("a_run_last_cnt", cycle_cnt_a, 499);
    wait_cyc(t0 + 506);
    chk("a_finished", finished_a, 1);
    chk("a_finish_done_low", done_a, 0);
    chk("a_finish_timeout", timeout_a, 1);
    chk("a_finish_cnt", cycle_cnt_a, 499);

    // Phase 2: restart, halt on the 20th RUN cycle.
    s = t0 + 510;
    wait_cyc(s);
    start_a = 1'b1;
`ifdef RUN_CTRL_HALT_EN
    q_a.push_back('{s + 26, 19, 0, 0, 20});
`else
    q_a.push_back('{s + 506, 499, 1, 0, 500});
`endif
    wait_cyc(s + 1);
    start_a = 1'b0;
    chk("a_restart_timeout", timeout_a, 0);
    chk("a_restart_cnt", cycle_cnt_a, 0);
    chk("a_restart_idx", run_idx_a, 0);
    wait_cyc(s + 25);
    halt_a = 1'b1;
    wait_cyc(s + 26);
    halt_a = 1'b0;

    // Phase 3: halt held high through the whole RUN.
    s2 = s + 510;
    wait_cyc(s2);
    start_a = 1'b1;
`ifdef RUN_CTRL_HALT_EN
    q_a.push_back('{s2 + 7, 0, 0, 0, 1});
`else
    q_a.push_back('{s2 + 506, 499, 1, 0, 500});
`endif
    wait_cyc(s2 + 1);
    start_a = 1'b0;
    wait_cyc(s2 + 6);
    halt_a = 1'b1;

    // Phase 4: asynchronous reset at RUN cycle 100.
    s3 = s2 + 510;
    wait_cyc(s3);
    halt_a  = 1'b0;
    start_a = 1'b1;
    wait_cyc(s3 + 1);
    start_a = 1'b0;
    wait_cyc(s3 + 106);
    chk("a_pre_abort_cnt", cycle_cnt_a, 100);
    #2 rst_a = 1'b0;
    #1;
    chk("a_abort_cpu_reset", cpu_reset_a, 1);
    chk("a_abort_running", running_a, 0);
    chk("a_abort_done", done_a, 0);
    chk("a_abort_cnt", cycle_cnt_a, 0);
    chk("a_abort_finished", finished_a, 0);
    wait_cyc(s3 + 109);
    rst_a = 1'b1;
    t4 = cyc;
    q_a.push_back('{t4 + 505, 499, 1, 0, 500});
    wait_cyc(t4 + 4);
    chk("a_rehold_cpu_reset", cpu_reset_a, 1);
    wait_cyc(t4 + 5);
    chk("a_rerun_running", running_a, 1);
    chk("a_rerun_cnt", cycle_cnt_a, 0);
    wait_cyc(t4 + 510);
    chk("a_pending_done", q_a.size(), 0);
    chk("b_pending_done", q_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 5, SHALL set core-reset hold length in clk cycles (>=1).
REQ-002 Parameter RUN_CYCLES, default 500, SHALL set the maximum run length in clk cycles (>=1).
REQ-003 Parameter NUM_RUNS, default 1, SHALL set the back-to-back runs per sequence (>=1).
REQ-004 Parameter CNT_W, default 16, SHALL set the cycle_cnt width and SHALL satisfy 2**CNT_W > max(RST_CYCLES, RUN_CYCLES).
REQ-005 The design SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset  in  1  asynchronous active-low reset.
REQ-008 start  in  1  sampled only in FINISH, restarts the sequence from run 0.
REQ-009 halt  in  1  core end-of-program indication, sampled only in RUN.
REQ-010 cpu_reset  out  1  synchronous active-high reset driven to the core under test.
REQ-011 running  out  1  high exactly in RUN.
REQ-012 run_idx  out  $clog2(NUM_RUNS)+1  index of the current run.
REQ-013 cycle_cnt  out  CNT_W  RUN cycles elapsed in the current run.
REQ-014 done  out  1  one-cycle pulse at end of each run.
REQ-015 timeout  out  1  the last run ended by RUN_CYCLES exhaustion, not by halt.
REQ-016 finished  out  1  high while in FINISH.

Function
REQ-017 FSM states SHALL be HOLD, RUN, END, FINISH.
REQ-018 HOLD SHALL drive cpu_reset=1, count RST_CYCLES cycles on an internal counter, and then enter RUN.
REQ-019 On entry to HOLD, cycle_cnt SHALL clear to 0.
REQ-020 RUN SHALL drive cpu_reset=0 and running=1, and SHALL increment cycle_cnt by 1 each cycle.
REQ-021 RUN SHALL go to END when cycle_cnt==RUN_CYCLES-1 or halt (per REQ-030).
REQ-022 END SHALL last exactly one cycle with done=1, cpu_reset=1, running=0, and cycle_cnt frozen at its final value.
REQ-023 On the cycle RUN goes to END, timeout SHALL be loaded: 1 on count exhaustion, 0 on halt; halt wins if both occur in the same cycle.
REQ-024 END SHALL go to FINISH if run_idx==NUM_RUNS-1, else to HOLD with run_idx incremented by 1.
REQ-025 FINISH SHALL hold cpu_reset=1, finished=1, and hold cycle_cnt, run_idx and timeout.
REQ-026 start=1 in FINISH SHALL enter HOLD with run_idx=0 and timeout=0.
REQ-027 start SHALL be ignored in every other state.
REQ-028 halt SHALL be ignored outside RUN.
REQ-029 No counter SHALL wrap: cycle_cnt maximum is RUN_CYCLES-1, and the hold counter maximum is RST_CYCLES-1.

Configuration
REQ-030 With RUN_CTRL_HALT_EN defined, halt SHALL terminate RUN per REQ-021/023; without it, halt SHALL be ignored and every run SHALL last RUN_CYCLES cycles with timeout=1.

Reset
REQ-031 reset low SHALL asynchronously force state=HOLD, hold counter=0, cycle_cnt=0, and run_idx=0.
REQ-032 reset low SHALL asynchronously force cpu_reset=1, running=0, done=0, timeout=0, finished=0.
REQ-033 reset asserted mid-run SHALL abort the run with no done pulse; after release, the sequence SHALL restart with RST_CYCLES cycles of HOLD.

Structure
REQ-034 Package run_ctrl_pkg SHALL hold the state encoding constants and the parameter-check macros/functions.
REQ-035 One sub-module, cyc_counter (CNT_W-bit up-counter with clear, enable and terminal-count compare), SHALL be instantiated twice: once for hold and once for run.

Verification
REQ-036 Defaults, reset released at cycle 0 -> cpu_reset=1 for cycles 0-4; running=1 for cycles 5-504; done pulse at cycle 505 with timeout=1 and cycle_cnt=499; finished=1 from cycle 506.
REQ-037 RUN_CTRL_HALT_EN, halt at the 20th RUN cycle -> done the next cycle, cycle_cnt=19, timeout=0.
REQ-038 NUM_RUNS=3, RUN_CYCLES=4, RST_CYCLES=2 -> three done pulses 7 cycles apart; run_idx steps 0,1,2; cpu_reset re-asserted for 2 cycles before each run.
REQ-039 Reset pulled low at RUN cycle 100 -> cpu_reset=1 and running=0 immediately, no done pulse, and a full HOLD then RUN restart after release.
REQ-040 start pulsed in FINISH, halt toggled in HOLD -> new sequence from run_idx=0; the halt in HOLD causes no early end.
REQ-041 Macro undefined, halt=1 throughout RUN -> the run still lasts RUN_CYCLES cycles with timeout=1.
